// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I/RV64I decode stage:
//   - base opcode constants (instr[6:0])
//   - instruction format codes carried on out_fmt
//   - decode_bundle_t, the decoded-instruction record held in the stage's
//     main and skid registers
// The bundle is sized for the widest datapath (64 bits); narrower
// instances use the low XLEN bits of pc and imm.
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int unsigned MAX_XLEN = 64;

    // Base opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Format codes
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] imm;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          fmt;
        logic                rs1_used;
        logic                rs2_used;
        logic                rd_we;
        logic                illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32I/RV64I decoder: raw instruction word + pc in,
// decode_bundle_t out. No state; the stage registers the result.
// Ports:
//   i_instr  [31:0]     raw instruction word
//   i_pc     [XLEN-1:0] instruction address (zero-extended into the bundle)
//   o_bundle            decoded fields, format, immediate, usage/illegal flags
// Immediates are always built sign-extended to 64 bits; the low XLEN bits
// are therefore the correct XLEN-wide sign extension as well.
// -----------------------------------------------------------------------------
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output decode_bundle_t  o_bundle
);

    logic [2:0]          w_fmt;
    logic [MAX_XLEN-1:0] w_imm;
    logic                w_is_rv64;

    assign w_is_rv64 = (XLEN == 64);

    // Format classification; anything not listed stays FMT_NONE (illegal).
    always_comb begin
        w_fmt = FMT_NONE;
        case (i_instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM:     w_fmt = FMT_I;
            OPC_OPIMM32:                  w_fmt = w_is_rv64 ? FMT_I : FMT_NONE;
            OPC_STORE:                    w_fmt = FMT_S;
            OPC_BRANCH:                   w_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:           w_fmt = FMT_U;
            OPC_JAL:                      w_fmt = FMT_J;
            OPC_OP:                       w_fmt = FMT_R;
            OPC_OP32:                     w_fmt = w_is_rv64 ? FMT_R : FMT_NONE;
            default:                      w_fmt = FMT_NONE;
        endcase
        // Compressed/reserved quadrants are never legal here.
        if (i_instr[1:0] != 2'b11) begin
            w_fmt = FMT_NONE;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = {{52{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm = {{52{i_instr[31]}}, i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            FMT_U:   w_imm = {{32{i_instr[31]}}, i_instr[31:12], 12'h000};
            FMT_J:   w_imm = {{44{i_instr[31]}}, i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        o_bundle          = '0;
        o_bundle.pc       = MAX_XLEN'(i_pc);
        o_bundle.imm      = w_imm;
        o_bundle.opcode   = i_instr[6:0];
        o_bundle.funct3   = i_instr[14:12];
        o_bundle.funct7   = i_instr[31:25];
        o_bundle.rd       = i_instr[11:7];
        o_bundle.rs1      = i_instr[19:15];
        o_bundle.rs2      = i_instr[24:20];
        o_bundle.fmt      = w_fmt;
        o_bundle.illegal  = (w_fmt == FMT_NONE);
        o_bundle.rs1_used = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                            (w_fmt == FMT_S) || (w_fmt == FMT_B);
        o_bundle.rs2_used = (w_fmt == FMT_R) || (w_fmt == FMT_S) ||
                            (w_fmt == FMT_B);
        // ECALL/EBREAK (SYSTEM, funct3=000) write nothing; x0 is never written.
        o_bundle.rd_we    = ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                             (w_fmt == FMT_U) || (w_fmt == FMT_J)) &&
                            !((i_instr[6:0] == OPC_SYSTEM) && (i_instr[14:12] == 3'b000)) &&
                            (i_instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered decode pipeline stage between fetch and register-read/execute.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything held plus any input of this cycle
//   in_valid/in_ready   upstream handshake; in_instr, in_pc carried with it
//   out_valid/out_ready downstream handshake
//   out_pc, out_rs1/rs2/rd, out_opcode/funct3/funct7, out_imm, out_fmt,
//   out_rs1_used, out_rs2_used, out_rd_we, out_illegal   decoded instruction
// Handshake: a beat moves when valid && ready on the same rising edge. Once
// out_valid is high, all out_* hold until out_ready is seen. Inputs reach the
// outputs only through a register (one cycle latency).
// SKID=1: main register + one skid entry; in_ready = !skid_full (derived
// from state only), full throughput. SKID=0: main register only, in_ready =
// !out_valid || out_ready.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    decode_bundle_t r_main;
    decode_bundle_t r_skid;
    logic           r_main_valid;
    logic           r_skid_valid;

    decode_bundle_t w_dec;
    logic           w_in_fire;
    logic           w_main_free;
    logic           w_ready_raw;
    logic           w_unused_hi;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .i_instr  (in_instr),
        .i_pc     (in_pc),
        .o_bundle (w_dec)
    );

    // Main register can take a new entry when empty or being drained.
    assign w_main_free = !r_main_valid || out_ready;
    assign w_ready_raw = (SKID != 0) ? !r_skid_valid : w_main_free;
    assign in_ready    = w_ready_raw && !rst;
    assign w_in_fire   = in_valid && in_ready;

    // With SKID=0 a stalled main register implies in_ready=0, so the skid
    // entry is never loaded and r_skid_valid stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                // Older skid entry goes first to preserve order.
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                if (w_in_fire) begin
                    r_skid <= w_dec;
                end else begin
                    r_skid_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid    = r_main_valid;
    assign out_pc       = r_main.pc[XLEN-1:0];
    assign out_imm      = r_main.imm[XLEN-1:0];
    assign out_rs1      = r_main.rs1;
    assign out_rs2      = r_main.rs2;
    assign out_rd       = r_main.rd;
    assign out_opcode   = r_main.opcode;
    assign out_funct3   = r_main.funct3;
    assign out_funct7   = r_main.funct7;
    assign out_fmt      = r_main.fmt;
    assign out_rs1_used = r_main.rs1_used;
    assign out_rs2_used = r_main.rs2_used;
    assign out_rd_we    = r_main.rd_we;
    assign out_illegal  = r_main.illegal;

    // Upper bundle bits are dead when XLEN=32.
    assign w_unused_hi = ^{r_main.pc, r_main.imm};

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        out_ready;

    int total;
    int bad;

    // XLEN=32, SKID=1
    logic        d32_in_ready, d32_out_valid;
    logic [31:0] d32_out_pc, d32_out_imm;
    logic [4:0]  d32_out_rs1, d32_out_rs2, d32_out_rd;
    logic [6:0]  d32_out_opcode, d32_out_funct7;
    logic [2:0]  d32_out_funct3, d32_out_fmt;
    logic        d32_out_rs1_used, d32_out_rs2_used, d32_out_rd_we, d32_out_illegal;
    // XLEN=64, SKID=1
    logic        d64_in_ready, d64_out_valid;
    logic [63:0] d64_out_pc, d64_out_imm;
    logic [4:0]  d64_out_rs1, d64_out_rs2, d64_out_rd;
    logic [6:0]  d64_out_opcode, d64_out_funct7;
    logic [2:0]  d64_out_funct3, d64_out_fmt;
    logic        d64_out_rs1_used, d64_out_rs2_used, d64_out_rd_we, d64_out_illegal;
    // XLEN=32, SKID=0
    logic        s0_in_ready, s0_out_valid;
    logic [31:0] s0_out_pc, s0_out_imm;
    logic [4:0]  s0_out_rs1, s0_out_rs2, s0_out_rd;
    logic [6:0]  s0_out_opcode, s0_out_funct7;
    logic [2:0]  s0_out_funct3, s0_out_fmt;
    logic        s0_out_rs1_used, s0_out_rs2_used, s0_out_rd_we, s0_out_illegal;

    decode_stage #(.XLEN(32), .SKID(1)) u_d32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d32_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(d32_out_valid), .out_ready(out_ready), .out_pc(d32_out_pc),
        .out_rs1(d32_out_rs1), .out_rs2(d32_out_rs2), .out_rd(d32_out_rd),
        .out_opcode(d32_out_opcode), .out_funct3(d32_out_funct3), .out_funct7(d32_out_funct7),
        .out_imm(d32_out_imm), .out_fmt(d32_out_fmt),
        .out_rs1_used(d32_out_rs1_used), .out_rs2_used(d32_out_rs2_used),
        .out_rd_we(d32_out_rd_we), .out_illegal(d32_out_illegal)
    );

    decode_stage #(.XLEN(64), .SKID(1)) u_d64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(d64_in_ready), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(d64_out_valid), .out_ready(out_ready), .out_pc(d64_out_pc),
        .out_rs1(d64_out_rs1), .out_rs2(d64_out_rs2), .out_rd(d64_out_rd),
        .out_opcode(d64_out_opcode), .out_funct3(d64_out_funct3), .out_funct7(d64_out_funct7),
        .out_imm(d64_out_imm), .out_fmt(d64_out_fmt),
        .out_rs1_used(d64_out_rs1_used), .out_rs2_used(d64_out_rs2_used),
        .out_rd_we(d64_out_rd_we), .out_illegal(d64_out_illegal)
    );

    decode_stage #(.XLEN(32), .SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(s0_out_valid), .out_ready(out_ready), .out_pc(s0_out_pc),
        .out_rs1(s0_out_rs1), .out_rs2(s0_out_rs2), .out_rd(s0_out_rd),
        .out_opcode(s0_out_opcode), .out_funct3(s0_out_funct3), .out_funct7(s0_out_funct7),
        .out_imm(s0_out_imm), .out_fmt(s0_out_fmt),
        .out_rs1_used(s0_out_rs1_used), .out_rs2_used(s0_out_rs2_used),
        .out_rd_we(s0_out_rd_we), .out_illegal(s0_out_illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0; in_pc64 = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (d32_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid32: got %b want 0", d32_out_valid); end
        total++; if (d64_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid64: got %b want 0", d64_out_valid); end
        total++; if (d32_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready32: got %b want 0", d32_in_ready); end
        total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_s0: got %b want 0", s0_in_ready); end
        total++;
        if ({d32_out_pc, d32_out_imm, d32_out_rs1, d32_out_rs2, d32_out_rd, d32_out_opcode,
             d32_out_funct3, d32_out_funct7, d32_out_fmt, d32_out_rs1_used, d32_out_rs2_used,
             d32_out_rd_we, d32_out_illegal} !== '0) begin
            bad++; $display("FAIL rst_data32: got pc=%h imm=%h fmt=%0d want all zero", d32_out_pc, d32_out_imm, d32_out_fmt);
        end
        total++; if (d64_out_imm !== 64'h0) begin bad++; $display("FAIL rst_imm64: got %h want 0", d64_out_imm); end
        rst = 1'b0;
        #1;
        total++; if (d32_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready32: got %b want 1", d32_in_ready); end
        total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready_s0: got %b want 1", s0_in_ready); end
        tick();
        total++; if (d32_in_ready !== 1'b1 || d32_out_valid !== 1'b0) begin bad++; $display("FAIL idle_after_rst: got rdy=%b vld=%b want 1/0", d32_in_ready, d32_out_valid); end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic [2:0]  use32;   // {rs1_used, rs2_used, rd_we}
        logic [2:0]  fmt64;
        logic [63:0] imm64;
        logic [2:0]  use64;
    } vec_t;

    task automatic test_decode();
        vec_t v[18];
        logic [31:0] ins;
        logic [31:0] pc;
        v[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 3'b101, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'b101}; // addi x1,x0,-1
        v[1]  = '{32'hFE208EE3, 3'd3, 32'hFFFFFFFC, 3'b110, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'b110}; // beq x1,x2,-4
        v[2]  = '{32'h123452B7, 3'd4, 32'h12345000, 3'b001, 3'd4, 64'h0000000012345000, 3'b001}; // lui x5,0x12345
        v[3]  = '{32'h800002B7, 3'd4, 32'h80000000, 3'b001, 3'd4, 64'hFFFFFFFF80000000, 3'b001}; // lui x5,0x80000
        v[4]  = '{32'h0020A423, 3'd2, 32'h00000008, 3'b110, 3'd2, 64'h0000000000000008, 3'b110}; // sw x2,8(x1)
        v[5]  = '{32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 3'b001, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'b001}; // jal x1,-4
        v[6]  = '{32'h002081B3, 3'd0, 32'h00000000, 3'b111, 3'd0, 64'h0000000000000000, 3'b111}; // add x3,x1,x2
        v[7]  = '{32'h00000013, 3'd1, 32'h00000000, 3'b100, 3'd1, 64'h0000000000000000, 3'b100}; // nop, rd=x0
        v[8]  = '{32'h000000F3, 3'd1, 32'h00000000, 3'b100, 3'd1, 64'h0000000000000000, 3'b100}; // SYSTEM f3=0 rd=1
        v[9]  = '{32'h000020F3, 3'd1, 32'h00000000, 3'b101, 3'd1, 64'h0000000000000000, 3'b101}; // csrrs x1,0,x0
        v[10] = '{32'h00000000, 3'd7, 32'h00000000, 3'b000, 3'd7, 64'h0000000000000000, 3'b000}; // all zero
        v[11] = '{32'hFFF00091, 3'd7, 32'h00000000, 3'b000, 3'd7, 64'h0000000000000000, 3'b000}; // low bits 01
        v[12] = '{32'hFFF0009B, 3'd7, 32'h00000000, 3'b000, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'b101}; // addiw
        v[13] = '{32'h002081BB, 3'd7, 32'h00000000, 3'b000, 3'd0, 64'h0000000000000000, 3'b111}; // addw
        v[14] = '{32'h00001117, 3'd4, 32'h00001000, 3'b001, 3'd4, 64'h0000000000001000, 3'b001}; // auipc x2,1
        v[15] = '{32'h0000000F, 3'd1, 32'h00000000, 3'b100, 3'd1, 64'h0000000000000000, 3'b100}; // fence-like, rd=x0
        v[16] = '{32'h000080E7, 3'd1, 32'h00000000, 3'b101, 3'd1, 64'h0000000000000000, 3'b101}; // jalr x1,0(x1)
        v[17] = '{32'hFF812283, 3'd1, 32'hFFFFFFF8, 3'b101, 3'd1, 64'hFFFFFFFFFFFFFFF8, 3'b101}; // lw x5,-8(x2)
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            ins      = v[i].instr;
            pc       = 32'h1000 + 32'(i * 4);
            in_instr = ins;
            in_pc    = pc;
            in_pc64  = {32'hA5A5_0000, pc};
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            total++; if (d32_out_valid !== 1'b1) begin bad++; $display("FAIL dec_valid32[%0d]: got %b want 1", i, d32_out_valid); end
            total++; if (d32_out_fmt !== v[i].fmt32) begin bad++; $display("FAIL dec_fmt32[%0d]: got %0d want %0d", i, d32_out_fmt, v[i].fmt32); end
            total++; if (d32_out_imm !== v[i].imm32) begin bad++; $display("FAIL dec_imm32[%0d]: got %h want %h", i, d32_out_imm, v[i].imm32); end
            total++; if ({d32_out_rs1_used, d32_out_rs2_used, d32_out_rd_we} !== v[i].use32) begin bad++; $display("FAIL dec_use32[%0d]: got %b want %b", i, {d32_out_rs1_used, d32_out_rs2_used, d32_out_rd_we}, v[i].use32); end
            total++; if (d32_out_illegal !== (v[i].fmt32 == 3'd7)) begin bad++; $display("FAIL dec_ill32[%0d]: got %b want %b", i, d32_out_illegal, (v[i].fmt32 == 3'd7)); end
            total++;
            if ({d32_out_opcode, d32_out_funct3, d32_out_funct7, d32_out_rd, d32_out_rs1, d32_out_rs2} !==
                {ins[6:0], ins[14:12], ins[31:25], ins[11:7], ins[19:15], ins[24:20]}) begin
                bad++; $display("FAIL dec_fields32[%0d]: got rd=%0d rs1=%0d rs2=%0d op=%h want rd=%0d rs1=%0d rs2=%0d op=%h",
                                i, d32_out_rd, d32_out_rs1, d32_out_rs2, d32_out_opcode, ins[11:7], ins[19:15], ins[24:20], ins[6:0]);
            end
            total++; if (d32_out_pc !== pc) begin bad++; $display("FAIL dec_pc32[%0d]: got %h want %h", i, d32_out_pc, pc); end
            total++; if (d64_out_fmt !== v[i].fmt64) begin bad++; $display("FAIL dec_fmt64[%0d]: got %0d want %0d", i, d64_out_fmt, v[i].fmt64); end
            total++; if (d64_out_imm !== v[i].imm64) begin bad++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, d64_out_imm, v[i].imm64); end
            total++; if ({d64_out_rs1_used, d64_out_rs2_used, d64_out_rd_we} !== v[i].use64) begin bad++; $display("FAIL dec_use64[%0d]: got %b want %b", i, {d64_out_rs1_used, d64_out_rs2_used, d64_out_rd_we}, v[i].use64); end
            total++; if (d64_out_illegal !== (v[i].fmt64 == 3'd7)) begin bad++; $display("FAIL dec_ill64[%0d]: got %b want %b", i, d64_out_illegal, (v[i].fmt64 == 3'd7)); end
            total++; if (d64_out_pc !== {32'hA5A5_0000, pc}) begin bad++; $display("FAIL dec_pc64[%0d]: got %h want %h", i, d64_out_pc, {32'hA5A5_0000, pc}); end
        end
        tick();
        total++; if (d32_out_valid !== 1'b0) begin bad++; $display("FAIL dec_drain: got %b want 0", d32_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[$];
        logic [31:0] pc;
        logic [31:0] exp_pc;
        int accepts;
        int fires;
        idle_cycles(2);
        pc = 32'h0; accepts = 0; fires = 0;
        in_instr  = 32'h00000013;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_pc = pc; in_pc64 = {32'h0, pc};
            if (d32_in_ready) begin exp_q.push_back(pc); pc += 4; accepts++; end
            tick();
        end
        total++; if (accepts != 2) begin bad++; $display("FAIL bp_stall_accepts: got %0d want 2", accepts); end
        total++; if (d32_in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_in_ready: got %b want 0", d32_in_ready); end
        total++; if (d32_out_valid !== 1'b1 || d32_out_pc !== 32'h0) begin bad++; $display("FAIL bp_stall_hold: got vld=%b pc=%h want 1/0", d32_out_valid, d32_out_pc); end
        out_ready = 1'b1;
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            in_pc = pc; in_pc64 = {32'h0, pc};
            if (d32_out_valid) begin
                fires++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: got pc=%h want nothing", d32_out_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (d32_out_pc !== exp_pc) begin bad++; $display("FAIL bp_order: got %h want %h", d32_out_pc, exp_pc); end
                end
            end
            if (d32_in_ready) begin exp_q.push_back(pc); pc += 4; if (c >= 1) accepts++; end
            tick();
        end
        total++; if (fires != 8) begin bad++; $display("FAIL bp_release_rate: got %0d outputs want 8", fires); end
        total++; if (accepts != 7) begin bad++; $display("FAIL bp_accept_rate: got %0d accepts want 7", accepts); end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (d32_out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_drain: got pc=%h want nothing", d32_out_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    if (d32_out_pc !== exp_pc) begin bad++; $display("FAIL bp_order_drain: got %h want %h", d32_out_pc, exp_pc); end
                end
            end
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_lost: got %0d missing want 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        int ghosts;
        idle_cycles(2);
        // main + skid full, input still offered during flush
        in_instr  = 32'hFFF00093;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'h100; in_pc64 = 64'h100; tick();
        in_pc = 32'h104; in_pc64 = 64'h104; tick();
        total++; if (d32_in_ready !== 1'b0 || d32_out_pc !== 32'h100) begin bad++; $display("FAIL flush_setup: got rdy=%b pc=%h want 0/100", d32_in_ready, d32_out_pc); end
        flush = 1'b1; in_pc = 32'h108; in_pc64 = 64'h108; tick();
        flush = 1'b0;
        total++; if (d32_out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid32: got %b want 0", d32_out_valid); end
        total++; if (d32_in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready32: got %b want 1", d32_in_ready); end
        total++; if (d64_out_valid !== 1'b0 || d64_in_ready !== 1'b1) begin bad++; $display("FAIL flush_full64: got vld=%b rdy=%b want 0/1", d64_out_valid, d64_in_ready); end
        // main full, skid empty: the input accepted in the flush cycle is dropped
        in_pc = 32'h110; in_pc64 = 64'h110; tick();
        flush = 1'b1; in_pc = 32'h114; in_pc64 = 64'h114; tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (d32_out_valid !== 1'b0 || d32_in_ready !== 1'b1) begin bad++; $display("FAIL flush_drop: got vld=%b rdy=%b want 0/1", d32_out_valid, d32_in_ready); end
        tick();
        total++; if (d32_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_skid_leak: got %b want 0", d32_out_valid); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h200; in_pc64 = 64'h200; tick();
        in_valid = 1'b0;
        total++; if (d32_out_valid !== 1'b1 || d32_out_pc !== 32'h200) begin bad++; $display("FAIL flush_next: got vld=%b pc=%h want 1/200", d32_out_valid, d32_out_pc); end
        ghosts = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (d32_out_valid) ghosts++;
        end
        total++; if (ghosts != 0) begin bad++; $display("FAIL flush_ghost: got %0d stray outputs want 0", ghosts); end
    endtask

    task automatic test_skid0();
        idle_cycles(2);
        out_ready = 1'b0;
        in_instr  = 32'h123452B7;
        in_pc     = 32'h300; in_pc64 = 64'h300;
        in_valid  = 1'b1;
        #1;
        total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_empty: got %b want 1", s0_in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (s0_out_valid !== 1'b1 || s0_out_pc !== 32'h300 || s0_out_imm !== 32'h12345000) begin bad++; $display("FAIL s0_out: got vld=%b pc=%h imm=%h want 1/300/12345000", s0_out_valid, s0_out_pc, s0_out_imm); end
        total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL s0_ready_stall: got %b want 0", s0_in_ready); end
        out_ready = 1'b1;
        #1;
        total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_ready_comb: got %b want 1", s0_in_ready); end
        tick();
        total++; if (s0_out_valid !== 1'b0) begin bad++; $display("FAIL s0_drain: got %b want 0", s0_out_valid); end
        idle_cycles(2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_skid0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
